muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit, parametrised in data width, that sits beside the single-cycle ALU in the EX stage of the RISC16 pipeline core.
- Performs unsigned multiply (low or high half) and unsigned divide (quotient or remainder) over WIDTH cycles, one bit per cycle.
- Uses a valid/ready handshake on both input and output.
- Carries a destination-register tag through to the result so the core can write back to the register file, and accepts a kill from branch/jump flush logic.

Parameters:
- WIDTH, 16, operand and result width in bits (≥4).
- TAG_W, 3, width of the destination-register tag carried with each operation.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request (high only in IDLE)
- op  input  2  00 MULLO, 01 MULHU, 10 DIVU, 11 REMU
- ain  input  WIDTH  multiplicand / dividend
- bin  input  WIDTH  multiplier / divisor
- tag_in  input  TAG_W  destination tag
- kill  input  1  abort any in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  selected result
- tag_out  output  TAG_W  tag of the result
- busy  output  1  state is BUSY or DONE

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, tag_out=0, iteration counter=0.
  - Reset mid-operation discards that operation with no out_valid.
- States are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - If in_valid=1 and kill=0 at an edge, the unit latches op, ain, bin and tag_in, clears the counter and goes to BUSY.
  - If kill=1 at that edge, the request is not accepted (kill wins).
- BUSY:
  - Performs one iteration per edge. The counter runs 0..WIDTH-1.
  - On the edge where the counter equals WIDTH-1, the state goes to DONE and the result register is loaded.
  - out_valid is therefore high starting exactly WIDTH edges after the accepting edge (16 for the default).
- Divide-by-zero (DIV/REM with bin==0):
  - Skips iteration. The state goes to DONE on the first edge after acceptance.
  - DIVU result = all ones; REMU result = ain.
- DONE:
  - out_valid=1. result and tag_out are held stable until the handshake.
  - When out_ready=1 at an edge, the state goes to IDLE and out_valid goes to 0.
  - in_ready stays 0 in DONE. A new request is accepted no earlier than the edge after the result is consumed.
- kill=1 at any edge in BUSY or DONE:
  - State goes to IDLE and out_valid goes to 0; the result is discarded.
  - kill and out_ready together in DONE: kill wins; the consumer must not treat the result as taken.
- Multiply:
  - Shift-add into a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - MULLO returns the product bits [WIDTH-1:0]; MULHU returns bits [2*WIDTH-1:WIDTH].
  - Arithmetic is unsigned with no overflow flag.
- Divide:
  - Restoring division, one quotient bit per cycle, MSB first.
  - WIDTH+1-bit partial remainder. The subtract is performed when the partial remainder ≥ divisor.
  - DIVU returns the quotient; REMU returns the final remainder.
- result and tag_out hold their last values in IDLE; they are only meaningful while out_valid=1.
- in_valid/op/ain/bin/tag_in are ignored outside IDLE. The unit never changes behaviour due to operand changes after acceptance.

Test Plan:
- Reset then MULLO/MULHU with ain=0x1234, bin=0x0056 → out_valid 16 cycles after accept; MULLO result=0x1D78, MULHU result=0x0006; tag_out equals tag_in.
- MULLO and MULHU with 0xFFFF×0xFFFF → MULLO=0x0001, MULHU=0xFFFE; hold out_ready=0 for 5 cycles → result stable, in_ready=0, a new in_valid is not accepted.
- DIVU/REMU with 0x03E8÷0x0007 → DIVU=0x008E, REMU=0x0006. Also 0x0005÷0x0009 → DIVU=0x0000, REMU=0x0005.
- DIVU/REMU by zero with ain=0x1234 → out_valid one cycle after accept; DIVU=0xFFFF, REMU=0x1234.
- kill asserted at iteration 7 of a multiply → IDLE next cycle, in_ready=1, out_valid never asserts; kill together with in_valid in IDLE → no accept.
- Kill/reset/back-to-back:
  - kill together with out_ready in DONE → out_valid drops and the next op runs cleanly.
  - rst mid-divide → all outputs at reset values.
  - Back-to-back ops with out_ready tied high → second accept occurs the edge after the first result is consumed.
  - Rerun the suite with WIDTH=8 and WIDTH=32 against a reference model.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide, one bit per cycle. Latency: WIDTH cycles from accept to out_valid, 1 cycle for divide-by-zero.
// Backpressure: a result is held in DONE until out_ready; in_ready is high only in IDLE; kill aborts at any point.
module muldiv_unit #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [TAG_W-1:0] tag_out,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [TAG_W-1:0]   tag_q;
   logic [CNT_W-1:0]   cnt;
   // Multiply: {partial product, unconsumed multiplier bits}. Divide: low half holds dividend/quotient.
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;

   logic               is_div;
   logic               div_zero;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quo_next;
   logic [WIDTH-1:0]   res_final;

   always_comb begin
      is_div    = op_q[1];
      div_zero  = is_div && (b_q == '0);
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {rem, acc[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, b_q};
      // When the subtract happens the difference is below the divisor, so it fits in WIDTH bits.
      rem_next  = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
      quo_next  = {acc[WIDTH-2:0], div_ge};
      case (op_q)
         2'b00:   res_final = mul_next[WIDTH-1:0];
         2'b01:   res_final = mul_next[2*WIDTH-1:WIDTH];
         2'b10:   res_final = quo_next;
         default: res_final = rem_next;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         tag_out   <= '0;
         cnt       <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         tag_q     <= '0;
         acc       <= '0;
         rem       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && !kill) begin
                  state    <= BUSY;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  op_q     <= op;
                  a_q      <= ain;
                  b_q      <= bin;
                  tag_q    <= tag_in;
                  cnt      <= '0;
                  acc      <= {{WIDTH{1'b0}}, (op[1] ? ain : bin)};
                  rem      <= '0;
               end
            end
            BUSY: begin
               if (kill) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end else if (div_zero) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  tag_out   <= tag_q;
                  result    <= op_q[0] ? a_q : '1;
               end else begin
                  acc <= is_div ? {acc[2*WIDTH-1:WIDTH], quo_next} : mul_next;
                  if (is_div) rem <= rem_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= res_final;
                     tag_out   <= tag_q;
                  end
               end
            end
            DONE: begin
               if (kill || out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand-written kill/reset/handshake sequences, random ops at WIDTH 16, 8 and 32.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [15:0] ain;
   logic [15:0] bin;
   logic [2:0]  tag_in;
   logic        kill;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [2:0]  tag_out;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;
   logic [1:0] w_done = 2'b00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(16), .TAG_W(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .ain(ain), .bin(bin), .tag_in(tag_in), .kill(kill), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .tag_out(tag_out), .busy(busy)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: the arithmetic definition of each op, independent of any iteration scheme.
   function automatic logic [15:0] ref16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      p = {16'h0, a} * {16'h0, b};
      case (o)
         2'b00:   return p[15:0];
         2'b01:   return p[31:16];
         2'b10:   return (b == 16'h0) ? 16'hFFFF : a / b;
         default: return (b == 16'h0) ? a : a % b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   // Starts and ends one time unit after a rising edge, unit in IDLE.
   task automatic run_op(input string nm, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] t, input logic [15:0] exp, input int exp_lat);
      int lat;
      check({nm, " in_ready"}, in_ready, 1);
      in_valid = 1'b1; op = o; ain = a; bin = b; tag_in = t;
      tick();
      in_valid = 1'b0; ain = ~a; bin = ~b; tag_in = ~t; op = ~o;
      wait_valid(lat);
      check({nm, " latency"}, lat, exp_lat);
      check({nm, " result"}, result, exp);
      check({nm, " tag"}, tag_out, t);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({nm, " released"}, {out_valid, in_ready, busy}, 3'b010);
   endtask

   typedef struct {
      string       nm;
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int lat;
      int seen;
      logic [1:0]  ro;
      logic [15:0] ra;
      logic [15:0] rb;

      tbl[0] = '{"mullo_1234x56",  2'b00, 16'h1234, 16'h0056, 16'h1D78, 16};
      tbl[1] = '{"mulhu_1234x56",  2'b01, 16'h1234, 16'h0056, 16'h0006, 16};
      tbl[2] = '{"mullo_ffffxffff",2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 16};
      tbl[3] = '{"mulhu_ffffxffff",2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16};
      tbl[4] = '{"divu_1000by7",   2'b10, 16'h03E8, 16'h0007, 16'h008E, 16};
      tbl[5] = '{"remu_1000by7",   2'b11, 16'h03E8, 16'h0007, 16'h0006, 16};
      tbl[6] = '{"divu_5by9",      2'b10, 16'h0005, 16'h0009, 16'h0000, 16};
      tbl[7] = '{"remu_5by9",      2'b11, 16'h0005, 16'h0009, 16'h0005, 16};
      tbl[8] = '{"divu_by0",       2'b10, 16'h1234, 16'h0000, 16'hFFFF, 1};
      tbl[9] = '{"remu_by0",       2'b11, 16'h1234, 16'h0000, 16'h1234, 1};

      rst = 1'b1; in_valid = 1'b0; op = 2'b00; ain = '0; bin = '0; tag_in = '0;
      kill = 1'b0; out_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      check("reset outputs", {in_ready, out_valid, busy, result, tag_out}, {3'b100, 16'h0, 3'h0});
      tick();

      for (int i = 0; i < 10; i++)
         run_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, 3'(i), tbl[i].exp, tbl[i].lat);

      // Result held under backpressure; requests in DONE are ignored.
      in_valid = 1'b1; op = 2'b01; ain = 16'hFFFF; bin = 16'hFFFF; tag_in = 3'd5;
      tick();
      in_valid = 1'b1; op = 2'b00; ain = 16'h0001; bin = 16'h0001; tag_in = 3'd2;
      wait_valid(lat);
      check("hold latency", lat, 16);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold stable", {out_valid, in_ready, result, tag_out}, {2'b10, 16'hFFFE, 3'd5});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      check("hold no accept in DONE", {in_ready, busy}, 2'b10);

      // Kill at iteration 7 of a multiply.
      in_valid = 1'b1; op = 2'b00; ain = 16'h1234; bin = 16'h0056; tag_in = 3'd3;
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check("kill busy", {in_ready, out_valid, busy}, 3'b100);
      seen = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("kill no result", seen, 0);

      // Kill with in_valid in IDLE: not accepted.
      in_valid = 1'b1; kill = 1'b1;
      tick();
      in_valid = 1'b0; kill = 1'b0;
      check("kill idle no accept", {in_ready, busy}, 2'b10);

      // Kill together with out_ready in DONE, then a clean op.
      in_valid = 1'b1; op = 2'b00; ain = 16'h0003; bin = 16'h0005; tag_in = 3'd4;
      tick();
      in_valid = 1'b0;
      wait_valid(lat);
      check("kill done latency", lat, 16);
      kill = 1'b1; out_ready = 1'b1;
      tick();
      kill = 1'b0; out_ready = 1'b0;
      check("kill done drop", {out_valid, in_ready}, 2'b01);
      run_op("after kill", 2'b10, 16'h03E8, 16'h0007, 3'd7, 16'h008E, 16);

      // Reset mid-divide.
      in_valid = 1'b1; op = 2'b10; ain = 16'h03E8; bin = 16'h0007; tag_in = 3'd6;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst mid-div outputs", {in_ready, out_valid, busy, result, tag_out}, {3'b100, 16'h0, 3'h0});
      seen = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("rst no result", seen, 0);

      // Back-to-back with out_ready tied high.
      out_ready = 1'b1;
      in_valid = 1'b1; op = 2'b00; ain = 16'h1234; bin = 16'h0056; tag_in = 3'd1;
      tick();
      check("b2b first accept", busy, 1);
      op = 2'b10; ain = 16'h03E8; bin = 16'h0007; tag_in = 3'd6;
      repeat (15) tick();
      check("b2b not early", out_valid, 0);
      tick();
      check("b2b first result", {out_valid, result, tag_out}, {1'b1, 16'h1D78, 3'd1});
      tick();
      check("b2b consumed", {out_valid, in_ready}, 2'b01);
      tick();
      check("b2b second accept", {in_ready, busy}, 2'b01);
      in_valid = 1'b0;
      repeat (15) tick();
      check("b2b second not early", out_valid, 0);
      tick();
      check("b2b second result", {out_valid, result, tag_out}, {1'b1, 16'h008E, 3'd6});
      tick();
      out_ready = 1'b0;
      check("b2b idle", {out_valid, in_ready}, 2'b01);

      // Random ops at WIDTH 16.
      for (int i = 0; i < 60; i++) begin
         ro = 2'($urandom);
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = 16'h0;
            1:       rb = 16'($urandom_range(1, 15));
            default: rb = 16'($urandom);
         endcase
         run_op($sformatf("w16 rnd%0d op%0d", i, ro), ro, ra, rb, 3'($urandom), ref16(ro, ra, rb),
                (ro[1] && rb == 16'h0) ? 1 : 16);
      end

      for (int i = 0; i < 20000 && w_done != 2'b11; i++) @(posedge clk);
      check("other widths finished", w_done, 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Random ops against the reference at WIDTH 8 and 32, each with its own instance and reset.
   for (genvar g = 0; g < 2; g++) begin : g_w
      localparam int W = (g == 0) ? 8 : 32;
      logic         rst_w, iv, ir, ov, orr, kl, bz;
      logic [1:0]   o;
      logic [W-1:0] a, b, r;
      logic [2:0]   ti, to;

      muldiv_unit #(.WIDTH(W), .TAG_W(3)) u_dut (
         .clk(clk), .rst(rst_w), .in_valid(iv), .in_ready(ir), .op(o),
         .ain(a), .bin(b), .tag_in(ti), .kill(kl), .out_valid(ov),
         .out_ready(orr), .result(r), .tag_out(to), .busy(bz)
      );

      initial begin
         logic [2*W-1:0] p;
         logic [W-1:0]   exp;
         logic [2:0]     t;
         int             lat;
         rst_w = 1'b1; iv = 1'b0; orr = 1'b0; kl = 1'b0; o = '0; a = '0; b = '0; ti = '0;
         repeat (2) @(posedge clk);
         #1 rst_w = 1'b0;
         check($sformatf("w%0d reset", W), {ir, ov, bz, r}, {3'b100, {W{1'b0}}});
         for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = W'($urandom);
            b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            t = 3'($urandom);
            ti = t;
            p = (2*W)'(a) * (2*W)'(b);
            case (o)
               2'b00:   exp = p[W-1:0];
               2'b01:   exp = p[2*W-1:W];
               2'b10:   exp = (b == '0) ? '1 : a / b;
               default: exp = (b == '0) ? a : a % b;
            endcase
            iv = 1'b1;
            @(posedge clk); #1;
            iv = 1'b0; a = ~a; b = ~b;
            lat = 0;
            while (!ov && lat < 200) begin
               @(posedge clk); #1;
               lat++;
            end
            check($sformatf("w%0d rnd%0d latency", W, i), lat, (o[1] && b == '1) ? 1 : W);
            check($sformatf("w%0d rnd%0d op%0d result", W, i, o), r, exp);
            check($sformatf("w%0d rnd%0d tag", W, i), to, t);
            orr = 1'b1;
            @(posedge clk); #1;
            orr = 1'b0;
         end
         w_done[g] = 1'b1;
      end
   end

endmodule
